mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the 5-stage MIPS pipeline.
- Accepts one decoded/executed instruction per handshake and performs LW/LB/SW/SB through a req/ack data-memory port.
- Produces the registered `reg_write`/`write_reg`/`write_data` triple that the decode stage consumes for register-file writes and same-cycle forwarding.
- Stalls upstream while a memory access is outstanding.

Parameters:
- ACK_TIMEOUT, 255: max cycles `mem_req` is held without `mem_ack` before abort (1..65535).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- op  in  6  opcode field
- if_reg_write  in  1  decode-stage write flag
- if_mem_read  in  1  load flag
- if_mem_write  in  1  store flag
- dest_reg  in  5  destination register
- alu_result  in  32  ALU result / effective address
- store_data  in  32  rt value for stores
- npc  in  32  link value for JAL
- mem_req  out  1  memory request
- mem_we  out  1  1=store, 0=load
- mem_addr  out  32  word address, bits[1:0]=0
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  access complete
- reg_write  out  1  register write pulse
- write_reg  out  5  register index
- write_data  out  32  register data
- stall  out  1  access outstanding
- align_err  out  1  one-cycle pulse, misaligned LW/SW
- bus_err  out  1  one-cycle pulse, ack timeout

Behaviour:
- Reset state: all outputs 0 except `in_ready`, which is 1. FSM=IDLE, timeout counter=0.
- Reset mid-access: `mem_req` drops immediately (async) and the pending instruction is discarded with no writeback.
- Accept: `in_valid` && `in_ready` at a rising edge. Upstream holds its inputs stable while `in_ready`=0.

Write enable:
- `wen` = (`if_reg_write` || op ∈ {000000, 001000, 001001, 001111}) && `dest_reg` != 0.

Writeback data:
- LW (100011): `mem_rdata`.
- LB (100000): sign-extended byte selected by `addr[1:0]` (0 → `rdata[7:0]`, 3 → `rdata[31:24]`).
- JAL (000011): `npc`.
- Otherwise: `alu_result`.

Memory access:
- Loads require `if_mem_read`=1; stores require `if_mem_write`=1. If the flag is clear, the op is treated as non-memory.
- `mem_addr` = {`alu_result[31:2]`, 2'b00}.
- SW: `mem_be`=1111, `mem_wdata`=`store_data`.
- SB: `mem_be`=1<<`addr[1:0]`, `mem_wdata`=`store_data[7:0]` replicated x4.
- LW/LB: `mem_be`=1111 / 1<<`addr[1:0]`, `mem_we`=0.

FSM:
- IDLE (`in_ready`=1, `stall`=0):
  - Accepted non-memory op: `reg_write`=`wen` for exactly the next cycle, with `write_reg`/`write_data`. Throughput is 1 instruction/cycle.
  - Accepted LW/SW with `addr[1:0]`≠0: no access, no write, `align_err` pulses the next cycle.
  - Accepted valid memory op: next cycle `mem_req`=1 with registered `we`/`addr`/`be`/`wdata`; go to ACCESS.
- ACCESS (`in_ready`=0, `stall`=1):
  - `mem_req` and all mem outputs stay stable until `mem_ack` is sampled. `mem_ack` is allowed in the first ACCESS cycle.
  - On ack: `mem_req`=0 next cycle.
    - Load: capture and extend `mem_rdata`; `reg_write`=`wen` for one cycle; go to WB.
    - Store: return to IDLE, no write.
  - Counter increments each ACCESS cycle. When it reaches ACK_TIMEOUT without ack: drop `mem_req`, pulse `bus_err`, no write, go to IDLE.
- WB (`in_ready`=0): one cycle while the load writeback is presented; then IDLE.
- Load latency: accept at edge N → `mem_req` high from N+1 → ack sampled at edge ≥N+2 → `reg_write` high for the cycle after that edge.
- `mem_ack` is ignored outside ACCESS. `reg_write` is never high for more than one cycle per instruction. `write_reg`/`write_data` hold their last values while `reg_write`=0.

Test Plan:
- Reset, then ADDIU with `dest_reg`=5, `alu_result`=0x1234 → one cycle later `reg_write`=1, `write_reg`=5, `write_data`=0x1234; back-to-back ALU ops give one write per cycle.
- LB at `alu_result`=0x102, `mem_rdata`=0x00F50000, ack after 3 cycles → `mem_addr`=0x100, `mem_be`=0100, `stall`=1 throughout, then one `reg_write` pulse with `write_data`=0xFFFFFFF5.
- SB at 0x203, `store_data`=0xAB → `mem_we`=1, `mem_be`=1000, `mem_wdata`=0xABABABAB, no `reg_write`.
- SW at 0x106 → no `mem_req`, `align_err` single pulse, `in_ready` stays 1.
- LW, never acked, ACK_TIMEOUT=4 → `mem_req` high 4 cycles then low, `bus_err` pulse, no write. Separately, assert `rst_n`=0 during ACCESS → `mem_req`=0 immediately and no writeback after release.
- JAL with `dest_reg`=31, `npc`=0x400008 → `write_reg`=31, `write_data`=0x400008; any op with `dest_reg`=0 → `reg_write` stays 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: issues LW/LB/SW/SB over a req/ack port,
// aligns load data and presents a single-cycle register-file write.
module mem_wb_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op,
  input  logic        if_reg_write,
  input  logic        if_mem_read,
  input  logic        if_mem_write,
  input  logic [4:0]  dest_reg,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] npc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;
  logic        is_lb_q, is_lb_d;
  logic [1:0]  lane_q, lane_d;
  logic        wen_q, wen_d;
  logic [4:0]  dest_q, dest_d;

  logic        is_lw, is_lb, is_sw, is_sb, is_mem, misaligned, wen, accept;
  logic [7:0]  load_byte;
  logic [31:0] load_data;

  always_comb begin
    is_lw      = (op == OP_LW) && if_mem_read;
    is_lb      = (op == OP_LB) && if_mem_read;
    is_sw      = (op == OP_SW) && if_mem_write;
    is_sb      = (op == OP_SB) && if_mem_write;
    is_mem     = is_lw || is_lb || is_sw || is_sb;
    misaligned = (is_lw || is_sw) && (alu_result[1:0] != 2'b00);
    wen        = (if_reg_write || op == 6'b000000 || op == 6'b001000 ||
                  op == 6'b001001 || op == 6'b001111) && (dest_reg != 5'd0);
    accept     = in_valid && (state_q == IDLE);
    case (lane_q)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_data = is_lb_q ? {{24{load_byte[7]}}, load_byte} : mem_rdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem && !misaligned) state_d = ACCESS;
      ACCESS: begin
        if (mem_ack)                    state_d = mem_we_q ? IDLE : WB;
        else if (cnt_q == TIMEOUT_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    align_err_d  = 1'b0;
    bus_err_d    = 1'b0;
    is_lb_d      = is_lb_q;
    lane_d       = lane_q;
    wen_d        = wen_q;
    dest_d       = dest_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            align_err_d = 1'b1;
          end else if (is_mem) begin
            cnt_d       = 16'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_sw || is_sb;
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_be_d    = (is_lw || is_sw) ? 4'b1111 : (4'b0001 << alu_result[1:0]);
            mem_wdata_d = is_sb ? {4{store_data[7:0]}} : store_data;
            is_lb_d     = is_lb;
            lane_d      = alu_result[1:0];
            wen_d       = wen;
            dest_d      = dest_reg;
          end else begin
            reg_write_d = wen;
            if (wen) begin
              write_reg_d  = dest_reg;
              write_data_d = (op == OP_JAL) ? npc : alu_result;
            end
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = 16'd0;
          if (!mem_we_q) begin
            reg_write_d = wen_q;
            if (wen_q) begin
              write_reg_d  = dest_q;
              write_data_d = load_data;
            end
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          cnt_d     = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      align_err_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      is_lb_q      <= 1'b0;
      lane_q       <= 2'd0;
      wen_q        <= 1'b0;
      dest_q       <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      align_err_q  <= align_err_d;
      bus_err_q    <= bus_err_d;
      is_lb_q      <= is_lb_d;
      lane_q       <= lane_d;
      wen_q        <= wen_d;
      dest_q       <= dest_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    stall      = (state_q == ACCESS);
    mem_req    = mem_req_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_be     = mem_be_q;
    mem_wdata  = mem_wdata_q;
    reg_write  = reg_write_q;
    write_reg  = write_reg_q;
    write_data = write_data_q;
    align_err  = align_err_q;
    bus_err    = bus_err_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of ALU/JAL writebacks plus
// hand-written load, store, misalignment, timeout and reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op;
  logic        if_reg_write, if_mem_read, if_mem_write;
  logic [4:0]  dest_reg;
  logic [31:0] alu_result, store_data, npc;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        stall, align_err, bus_err;

  int compared = 0;
  int mismatched = 0;

  mem_wb_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .if_reg_write(if_reg_write), .if_mem_read(if_mem_read),
    .if_mem_write(if_mem_write), .dest_reg(dest_reg), .alu_result(alu_result),
    .store_data(store_data), .npc(npc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .stall(stall),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        irw;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] npc;
    logic        exp_rw;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] o, input logic irw,
                               input logic mr, input logic mw, input logic [4:0] d,
                               input logic [31:0] alu, input logic [31:0] sd,
                               input logic [31:0] pc);
    in_valid = v; op = o; if_reg_write = irw; if_mem_read = mr; if_mem_write = mw;
    dest_reg = d; alu_result = alu; store_data = sd; npc = pc;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int req_cnt, berr_cnt, rw_cnt;

    vecs[0] = '{6'b001001, 1'b0, 5'd5,  32'h0000_1234, 32'h0,        1'b1, 5'd5,  32'h0000_1234};
    vecs[1] = '{6'b000000, 1'b0, 5'd7,  32'hDEAD_BEEF, 32'h0,        1'b1, 5'd7,  32'hDEAD_BEEF};
    vecs[2] = '{6'b000011, 1'b1, 5'd31, 32'h0000_0055, 32'h0040_0008, 1'b1, 5'd31, 32'h0040_0008};
    vecs[3] = '{6'b001000, 1'b0, 5'd0,  32'h0000_0099, 32'h0,        1'b0, 5'd31, 32'h0040_0008};
    vecs[4] = '{6'b001101, 1'b0, 5'd9,  32'h0000_0077, 32'h0,        1'b0, 5'd31, 32'h0040_0008};
    vecs[5] = '{6'b001101, 1'b1, 5'd9,  32'h0000_0077, 32'h0,        1'b1, 5'd9,  32'h0000_0077};
    vecs[6] = '{6'b001111, 1'b0, 5'd3,  32'hABCD_0000, 32'h0,        1'b1, 5'd3,  32'hABCD_0000};
    vecs[7] = '{6'b001010, 1'b1, 5'd0,  32'h0000_0001, 32'h0,        1'b0, 5'd3,  32'hABCD_0000};

    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    idleInputs();
    #12;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset reg_write", {31'd0, reg_write}, 32'd0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset write_data", write_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back non-memory ops: each result appears the cycle after accept.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput($sformatf("vec%0d reg_write", i-1), {31'd0, reg_write}, {31'd0, vecs[i-1].exp_rw});
        checkOutput($sformatf("vec%0d write_reg", i-1), {27'd0, write_reg}, {27'd0, vecs[i-1].exp_reg});
        checkOutput($sformatf("vec%0d write_data", i-1), write_data, vecs[i-1].exp_data);
        checkOutput($sformatf("vec%0d in_ready", i-1), {31'd0, in_ready}, 32'd1);
      end
      if (i < 8)
        applyStimulus(1'b1, vecs[i].op, vecs[i].irw, 1'b0, 1'b0, vecs[i].dest,
                      vecs[i].alu, 32'd0, vecs[i].npc);
      else
        idleInputs();
    end

    // LB at 0x102, ack sampled on the third ACCESS edge.
    @(negedge clk);
    applyStimulus(1'b1, 6'b100000, 1'b1, 1'b1, 1'b0, 5'd4, 32'h102, 32'd0, 32'd0);
    mem_rdata = 32'h00F5_0000;
    @(negedge clk);
    idleInputs();
    checkOutput("lb mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("lb mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("lb mem_addr", mem_addr, 32'h100);
    checkOutput("lb mem_be", {28'd0, mem_be}, 32'h4);
    checkOutput("lb in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("lb stall held", {31'd0, stall}, 32'd1);
      checkOutput("lb req held", {31'd0, mem_req}, 32'd1);
      checkOutput("lb no early write", {31'd0, reg_write}, 32'd0);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("lb req dropped", {31'd0, mem_req}, 32'd0);
    checkOutput("lb reg_write", {31'd0, reg_write}, 32'd1);
    checkOutput("lb write_reg", {27'd0, write_reg}, 32'd4);
    checkOutput("lb write_data", write_data, 32'hFFFF_FFF5);
    checkOutput("lb wb in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("lb single pulse", {31'd0, reg_write}, 32'd0);
    checkOutput("lb back idle", {31'd0, in_ready}, 32'd1);

    // SB at 0x203, acked in the first ACCESS cycle.
    applyStimulus(1'b1, 6'b101000, 1'b0, 1'b0, 1'b1, 5'd0, 32'h203, 32'h0000_00AB, 32'd0);
    @(negedge clk);
    idleInputs();
    checkOutput("sb mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("sb mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("sb mem_addr", mem_addr, 32'h200);
    checkOutput("sb mem_be", {28'd0, mem_be}, 32'h8);
    checkOutput("sb mem_wdata", mem_wdata, 32'hABAB_ABAB);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("sb req dropped", {31'd0, mem_req}, 32'd0);
    checkOutput("sb no write", {31'd0, reg_write}, 32'd0);
    checkOutput("sb idle", {31'd0, in_ready}, 32'd1);

    // Misaligned SW.
    applyStimulus(1'b1, 6'b101011, 1'b0, 1'b0, 1'b1, 5'd0, 32'h106, 32'h1111_2222, 32'd0);
    @(negedge clk);
    idleInputs();
    checkOutput("sw align_err", {31'd0, align_err}, 32'd1);
    checkOutput("sw no req", {31'd0, mem_req}, 32'd0);
    checkOutput("sw in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    checkOutput("sw align_err pulse", {31'd0, align_err}, 32'd0);

    // LW never acked: abort after ACK_TIMEOUT=4 request cycles.
    applyStimulus(1'b1, 6'b100011, 1'b1, 1'b1, 1'b0, 5'd6, 32'h300, 32'd0, 32'd0);
    req_cnt = 0; berr_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) idleInputs();
      if (mem_req) req_cnt++;
      if (bus_err) berr_cnt++;
      if (reg_write) rw_cnt++;
    end
    checkOutput("timeout req cycles", req_cnt, 32'd4);
    checkOutput("timeout bus_err pulses", berr_cnt, 32'd1);
    checkOutput("timeout no write", rw_cnt, 32'd0);
    checkOutput("timeout idle", {31'd0, in_ready}, 32'd1);

    // Reset while a load is outstanding.
    applyStimulus(1'b1, 6'b100011, 1'b1, 1'b1, 1'b0, 5'd8, 32'h400, 32'd0, 32'd0);
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    idleInputs();
    checkOutput("rst pre req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst async req drop", {31'd0, mem_req}, 32'd0);
    checkOutput("rst async in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    rw_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (reg_write) rw_cnt++;
    end
    mem_ack = 1'b0;
    checkOutput("rst no writeback", rw_cnt, 32'd0);
    checkOutput("rst write_data cleared", write_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
